div34_seq_gen: RTL and testbench



---
 rtl/div34_seq_gen_if.sv | 35 +++
 rtl/div34_seq_gen.sv | 195 +++++++++++++++++++
 tb/tb_div34_seq_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div34_seq_gen_if.sv
// Handshake bundle between the divisible-by-3-or-4 sequence source and its consumer.
// The serial pins exist only when DIV34_SER_OUT_EN is defined.
interface div34_seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             ready;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic             busy;
    logic             done;
`ifdef DIV34_SER_OUT_EN
    logic             ser_data;
    logic             ser_frame;

    modport master (
        input  start, stop, ready,
        output value, valid, busy, done, ser_data, ser_frame
    );
    modport slave (
        output start, stop, ready,
        input  value, valid, busy, done, ser_data, ser_frame
    );
`else
    modport master (
        input  start, stop, ready,
        output value, valid, busy, done
    );
    modport slave (
        output start, stop, ready,
        input  value, valid, busy, done
    );
`endif
endinterface

// File: rtl/div34_seq_gen.sv
// Scans 0..2^WIDTH-1 and emits codes divisible by 3 or 4 over a valid/ready handshake.
// Optional serial echo of each accepted word is enabled by defining DIV34_SER_OUT_EN.
module div34_seq_gen #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    div34_seq_gen_if.master   bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef DIV34_SER_OUT_EN
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] BIT_LAST = 3'(WIDTH - 1);
`endif
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Residue of cnt modulo 3 advances in lock-step with cnt, so no divider is needed.
    function automatic logic [1:0] mod3_inc(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]       mod3_q, mod3_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_s;
`ifdef DIV34_SER_OUT_EN
    logic             ser_data_q, ser_data_d;
    logic             ser_frame_q, ser_frame_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
`endif

    assign hit_s = (mod3_q == 2'd0) || (cnt_q[1:0] == 2'b00);

    // Next-state and output computation; stop overrides every non-idle state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mod3_d  = mod3_q;
        value_d = value_q;
        valid_d = valid_q;
        done_d  = 1'b0;
`ifdef DIV34_SER_OUT_EN
        ser_data_d  = ser_data_q;
        ser_frame_d = ser_frame_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
`endif
        if (bus.stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
`ifdef DIV34_SER_OUT_EN
            ser_frame_d = 1'b0;
            ser_data_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        cnt_d   = {WIDTH{1'b0}};
                        mod3_d  = 2'd0;
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        value_d = cnt_q;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        mod3_d = mod3_inc(mod3_q);
                    end
                end
                ST_HOLD: begin
                    if (valid_q && bus.ready) begin
                        valid_d = 1'b0;
`ifdef DIV34_SER_OUT_EN
                        // The word is serialised first; the last-word decision waits for SHIFT to end.
                        ser_frame_d = 1'b1;
                        ser_data_d  = value_q[WIDTH-1];
                        shift_d     = {value_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d   = 3'd0;
                        state_d     = ST_SHIFT;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d  = cnt_q + CNT_ONE;
                            mod3_d = mod3_inc(mod3_q);
                        end else begin
                            cnt_d = cnt_q;
                        end
`else
                        if (cnt_q == CNT_MAX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                            mod3_d  = mod3_inc(mod3_q);
                            state_d = ST_SCAN;
                        end
`endif
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
`ifdef DIV34_SER_OUT_EN
                ST_SHIFT: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        ser_frame_d = 1'b0;
                        ser_data_d  = 1'b0;
                        if (value_q == CNT_MAX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end else begin
                        ser_data_d = shift_q[WIDTH-1];
                        shift_d    = {shift_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset clears everything so no stale word survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {WIDTH{1'b0}};
            mod3_q  <= 2'd0;
            value_q <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV34_SER_OUT_EN
            ser_data_q  <= 1'b0;
            ser_frame_q <= 1'b0;
            shift_q     <= {WIDTH{1'b0}};
            bit_cnt_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mod3_q  <= mod3_d;
            value_q <= value_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV34_SER_OUT_EN
            ser_data_q  <= ser_data_d;
            ser_frame_q <= ser_frame_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign bus.value = value_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
`ifdef DIV34_SER_OUT_EN
    assign bus.ser_data  = ser_data_q;
    assign bus.ser_frame = ser_frame_q;
`endif
endmodule

// File: tb/tb_div34_seq_gen.sv
// Self-checking bench for div34_seq_gen: expected words come from a modulo-arithmetic model.
// Exercises the serial echo as well when DIV34_SER_OUT_EN is defined.
module tb_div34_seq_gen;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    div34_seq_gen_if #(.WIDTH(W)) bus ();

    div34_seq_gen #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", {31'd0, bus.busy}, 32'd1);
        chk("start_valid", {31'd0, bus.valid}, 32'd0);
    endtask

    // Runs one scan to completion; ready may be randomised, start may be poked, one word may be stalled.
    task automatic run_scan(input bit rand_ready, input bit poke_start, input int stall_word);
        int   idx = 0;
        int   dones = 0;
        int   stall = 0;
        int   cyc = 0;
        bit   finished = 1'b0;
        bit   first = 1'b1;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [W-1:0] pval = '0;
        while (!finished && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                chk("first_valid", {31'd0, bus.valid}, 32'd1);
                chk("first_value", 32'(bus.value), 32'd0);
                first = 1'b0;
            end
            if (pv && !pr) begin
                chk("hold_valid", {31'd0, bus.valid}, 32'd1);
                chk("hold_value", 32'(bus.value), 32'(pval));
            end
            if (bus.valid) begin
                if (idx < exp_q.size()) chk("word", 32'(bus.value), 32'(exp_q[idx]));
                else chk("extra_word", 32'(idx), 32'(exp_q.size() - 1));
            end
            if (bus.done) begin
                dones++;
                chk("done_after_last", 32'(idx), 32'(exp_q.size()));
                chk("done_valid", {31'd0, bus.valid}, 32'd0);
            end
            if (dones > 0 && !bus.busy) begin
                finished = 1'b1;
            end else begin
                if (bus.valid && (int'(bus.value) == stall_word) && stall < 5) begin
                    bus.ready = 1'b0;
                    stall++;
                end else begin
                    bus.ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
                bus.start = poke_start && ($urandom_range(0, 3) == 0);
                if (bus.valid && bus.ready) idx++;
                pv   = bus.valid;
                pr   = bus.ready;
                pval = bus.value;
            end
        end
        bus.start = 1'b0;
        bus.ready = 1'b0;
        chk("scan_finished", {31'd0, finished}, 32'd1);
        chk("word_count", 32'(idx), 32'(exp_q.size()));
        chk("done_pulses", 32'(dones), 32'd1);
        chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
        chk("done_after_idle", {31'd0, bus.done}, 32'd0);
        if (stall_word >= 0) chk("stall_cycles", 32'(stall), 32'd5);
    endtask

    // Consumes words with ready=1 until the given word is presented, then parks with ready=0.
    task automatic advance_to(input int word, output bit ok);
        int cyc = 0;
        ok = 1'b0;
        while (!ok && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.valid && int'(bus.value) == word) begin
                bus.ready = 1'b0;
                ok = 1'b1;
            end else begin
                bus.ready = 1'b1;
            end
        end
    endtask

    initial begin
        bit ok;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ready = 1'b0;
        for (int v = 0; v <= MAXV; v++) begin
            if ((v % 3 == 0) || (v % 4 == 0)) exp_q.push_back(v);
        end

        repeat (3) @(negedge clk);
        chk("rst_value", 32'(bus.value), 32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef DIV34_SER_OUT_EN
        chk("rst_ser_frame", {31'd0, bus.ser_frame}, 32'd0);
        chk("rst_ser_data", {31'd0, bus.ser_data}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Full scan with ready held high.
        do_start();
        run_scan(1'b0, 1'b0, -1);

        // Stall on word 6 for five cycles.
        do_start();
        run_scan(1'b0, 1'b0, 6);

        // Random back-pressure with stray start pulses.
        do_start();
        run_scan(1'b1, 1'b1, -1);

        // Abort while word 4 is presented, then restart from zero.
        do_start();
        advance_to(4, ok);
        chk("reach_4", {31'd0, ok}, 32'd1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_valid", {31'd0, bus.valid}, 32'd0);
        chk("stop_busy", {31'd0, bus.busy}, 32'd0);
        chk("stop_done", {31'd0, bus.done}, 32'd0);
        do_start();
        run_scan(1'b0, 1'b0, -1);

        // stop beats start while idle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("stop_start_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("stop_start_valid", {31'd0, bus.valid}, 32'd0);
        chk("stop_start_busy2", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset while word 9 is held.
        do_start();
        advance_to(9, ok);
        chk("reach_9", {31'd0, ok}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.valid}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_value", 32'(bus.value), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, bus.valid}, 32'd0);
            chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
            chk("post_rst_done", {31'd0, bus.done}, 32'd0);
        end

`ifdef DIV34_SER_OUT_EN
        begin
            logic [W-1:0] w12;
            int           cyc;
            w12 = W'(12);
            do_start();
            advance_to(12, ok);
            chk("reach_12", {31'd0, ok}, 32'd1);
            bus.ready = 1'b1;
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                bus.ready = 1'b0;
                chk("ser_frame_on", {31'd0, bus.ser_frame}, 32'd1);
                chk("ser_bit", {31'd0, bus.ser_data}, {31'd0, w12[W-1-i]});
            end
            @(negedge clk);
            chk("ser_frame_off", {31'd0, bus.ser_frame}, 32'd0);
            cyc = 0;
            while (!bus.valid && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("ser_next_valid", {31'd0, bus.valid}, 32'd1);
            chk("ser_next_word", 32'(bus.value), 32'd15);
            bus.ready = 1'b1;
            cyc = 0;
            while (bus.busy && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            bus.ready = 1'b0;
            chk("ser_drain_idle", {31'd0, bus.busy}, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
